// File: rtl/alu_md.sv
// alu_md: multicycle-datapath ALU with an iterative multiply/divide unit.
// The single-cycle ops produce a combinational result and a registered alu_out.
// MULTU and DIVU run one bit per cycle (shift-add multiply, restoring divide),
// write HI/LO on completion and raise done for one cycle.
// Optional feature macro: ALU_MD_SIGNED_EN. When it is defined, MULT (10) and
// DIV (11) are also accepted. They use the unsigned engine on magnitudes and
// correct the signs on the completion edge.
module alu_md #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             alu_src_a,
    input  logic [1:0]       alu_src_b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [IMM_W-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_MULTU = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;
`ifdef ALU_MD_SIGNED_EN
    localparam logic [3:0] OP_MULT  = 4'd10;
    localparam logic [3:0] OP_DIV   = 4'd11;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   result_next;
    logic [WIDTH-1:0]   alu_out_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg;

    // Multiply/divide engine state. opb_reg holds the multiplicand or divisor.
    // prod_reg is the {upper, multiplier} shift register for multiply.
    // rem_reg/quo_reg hold the partial remainder and the dividend/quotient.
    logic [WIDTH-1:0]   opb_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [WIDTH-1:0]   rem_reg, quo_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               neg_q_reg, neg_a_reg, dz_reg;

    logic               launch_signed, launch_mul, launch_div;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_prod_next, mul_final;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next, div_quo_next;
    logic [WIDTH-1:0]   div_lo_final, div_hi_final;

    // Operand selection: A from pc or reg_a; B from reg_b, 1 or the extended immediate.
    always_comb begin
        op_a = alu_src_a ? reg_a : pc;
        op_b = reg_b;
        case (alu_src_b)
            2'b00:   op_b = reg_b;
            2'b01:   op_b = WIDTH'(1);
            2'b10:   op_b = WIDTH'($signed(imm));
            default: op_b = WIDTH'(imm);
        endcase
    end

    // Single-cycle ALU. Opcodes 8-15 produce 0 here, so zero=1 for them.
    always_comb begin
        result_next = '0;
        case (op)
            OP_ADD:  result_next = op_a + op_b;
            OP_SUB:  result_next = op_a - op_b;
            OP_AND:  result_next = op_a & op_b;
            OP_OR:   result_next = op_a | op_b;
            OP_NOR:  result_next = ~(op_a | op_b);
            OP_XOR:  result_next = op_a ^ op_b;
            OP_SLT:  result_next = WIDTH'($signed(op_a) < $signed(op_b));
            OP_SLTU: result_next = WIDTH'(op_a < op_b);
            default: result_next = '0;
        endcase
    end

    assign result = result_next;
    assign zero   = (result_next == '0);

    // Decode which multicycle op a start would launch. Unsupported codes never launch.
`ifdef ALU_MD_SIGNED_EN
    assign launch_signed = (op == OP_MULT) || (op == OP_DIV);
    assign launch_mul    = start && ((op == OP_MULTU) || (op == OP_MULT));
    assign launch_div    = start && ((op == OP_DIVU)  || (op == OP_DIV));
`else
    assign launch_signed = 1'b0;
    assign launch_mul    = start && (op == OP_MULTU);
    assign launch_div    = start && (op == OP_DIVU);
`endif

    // Signed ops feed the unsigned engine with magnitudes.
    // The most negative value maps to 2^(WIDTH-1), which is still correct when read as unsigned.
    assign neg_a = launch_signed && op_a[WIDTH-1];
    assign neg_b = launch_signed && op_b[WIDTH-1];
    assign mag_a = neg_a ? (~op_a + WIDTH'(1)) : op_a;
    assign mag_b = neg_b ? (~op_b + WIDTH'(1)) : op_b;

    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

    // One iteration of the multiply and divide engines, plus sign correction on completion.
    always_comb begin
        mul_sum       = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                      + (prod_reg[0] ? {1'b0, opb_reg} : {(WIDTH+1){1'b0}});
        mul_prod_next = {mul_sum, prod_reg[WIDTH-1:1]};
        mul_final     = neg_q_reg ? (~mul_prod_next + (2*WIDTH)'(1)) : mul_prod_next;

        div_shift     = {rem_reg, quo_reg[WIDTH-1]};
        div_diff      = div_shift - {1'b0, opb_reg};
        div_ge        = ~div_diff[WIDTH];
        div_rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_next  = {quo_reg[WIDTH-2:0], div_ge};
        // Most-negative / -1 comes out as quotient 2^(WIDTH-1) with no negation,
        // which is already the required most-negative value with a zero remainder.
        div_lo_final  = neg_q_reg ? (~div_quo_next + WIDTH'(1)) : div_quo_next;
        div_hi_final  = neg_a_reg ? (~div_rem_next + WIDTH'(1)) : div_rem_next;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Start is only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (launch_mul) begin
                    state_next = MUL;
                end else if (launch_div) begin
                    state_next = DIV;
                end
            end
            MUL: begin
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            DIV: begin
                if (dz_reg || last_iter) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: alu_out tracking, operand latching, iteration and HI/LO write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
            opb_reg     <= '0;
            prod_reg    <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            cnt_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_a_reg   <= 1'b0;
            dz_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                alu_out_reg <= result_next;
            end
            case (state_reg)
                IDLE: begin
                    if (launch_mul) begin
                        opb_reg   <= mag_b;
                        prod_reg  <= {{WIDTH{1'b0}}, mag_a};
                        cnt_reg   <= '0;
                        neg_q_reg <= neg_a ^ neg_b;
                        neg_a_reg <= neg_a;
                        dz_reg    <= 1'b0;
                    end else if (launch_div) begin
                        opb_reg   <= mag_b;
                        rem_reg   <= '0;
                        // A zero divisor skips iteration and returns the raw dividend in hi.
                        quo_reg   <= (op_b == '0) ? op_a : mag_a;
                        cnt_reg   <= '0;
                        neg_q_reg <= neg_a ^ neg_b;
                        neg_a_reg <= neg_a;
                        dz_reg    <= (op_b == '0);
                    end
                end
                MUL: begin
                    prod_reg <= mul_prod_next;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        hi_reg   <= mul_final[2*WIDTH-1:WIDTH];
                        lo_reg   <= mul_final[WIDTH-1:0];
                        done_reg <= 1'b1;
                    end
                end
                DIV: begin
                    if (dz_reg) begin
                        lo_reg   <= '1;
                        hi_reg   <= quo_reg;
                        done_reg <= 1'b1;
                    end else begin
                        rem_reg <= div_rem_next;
                        quo_reg <= div_quo_next;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (last_iter) begin
                            lo_reg   <= div_lo_final;
                            hi_reg   <= div_hi_final;
                            done_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_out = alu_out_reg;
    assign hi      = hi_reg;
    assign lo      = lo_reg;
    assign done    = done_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor of the multicycle datapath ALU.
- Adds SLT/SLTU/XOR to the single-cycle ops.
- Adds an iterative multiply/divide unit with its own HI/LO result registers and a start/busy/done handshake.
- Sits between the register file/PC muxing and ALUOut in the multicycle CPU. The control FSM holds its current state while busy=1.

Parameters:
- WIDTH, 32, datapath width. Legal values: even, >=16.
- IMM_W, 16, immediate field width. Must be <= WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  launch mul/div when op is a multicycle op; ignored otherwise
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLT, 7 SLTU, 8 MULTU, 9 DIVU, 10 MULT, 11 DIV
- alu_src_a  in  1  0: A=pc, 1: A=reg_a
- alu_src_b  in  2  00 reg_b, 01 constant 1, 10 sign-extended imm, 11 zero-extended imm
- pc, reg_a, reg_b  in  WIDTH  operand sources
- imm  in  IMM_W  immediate field
- result  out  WIDTH  combinational single-cycle result
- zero  out  1  combinational, result==0
- alu_out  out  WIDTH  registered result
- hi, lo  out  WIDTH  mul/div result registers
- busy  out  1  multicycle op in progress
- done  out  1  one-cycle pulse: hi/lo just updated

Behaviour:
- Reset: alu_out=0, hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation aborts the operation with no hi/lo update.
- Operand selection is combinational.
- ADD/SUB wrap modulo 2^WIDTH.
- SLT is a signed compare; SLTU is unsigned. Result is 1 or 0, zero-extended to WIDTH.
- For ops 8-15, result=0 (zero=1).
- alu_out<=result every edge while state==IDLE; it holds while busy.
- FSM states: IDLE, MUL, DIV.
  - IDLE to MUL/DIV on start=1 with op 8/9 (or 10/11, see Optional Feature). Operands are latched on that edge; counter=0.
  - Start is honoured in IDLE only, including the cycle where done=1. Start while busy is ignored.
  - busy=1 exactly while state!=IDLE.
- MUL: shift-add, one bit per cycle, WIDTH cycles.
  - On the final iteration edge: {hi,lo}<=2*WIDTH-bit product; state->IDLE; done<=1.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles.
  - Result: lo=quotient, hi=remainder.
- Latency: start accepted at edge E. busy is high for WIDTH cycles after E. hi/lo and done are valid after edge E+WIDTH. done drops on the next edge.
- Divide by zero: no iteration. On the edge after acceptance: lo=all ones, hi=dividend, done=1; busy is high for that single cycle.
- Ops 12-15: start ignored, hi/lo unchanged.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro ALU_MD_SIGNED_EN.
- Defined: ops 10 MULT and 11 DIV are supported.
  - Operands are converted to magnitudes and run through the same unsigned iterations; signs are fixed at completion with no extra cycle.
  - Quotient sign = sign(a) xor sign(b); remainder takes the sign of the dividend.
  - Signed divide by zero: lo=all ones, hi=dividend.
  - Overflow case (most negative / -1): lo=most negative, hi=0.
- Undefined: ops 10/11 behave like ops 12-15 (result 0, start ignored, no state change).

Test Plan:
- WIDTH=32, alu_src_a=1, alu_src_b=10, reg_a=5, imm=0xFFFF, op ADD -> result=4, zero=0; alu_out=4 after next edge.
- op SLT with reg_a=0xFFFFFFFF, reg_b=1 -> result=1; op SLTU with the same operands -> result=0.
- MULTU 0xFFFFFFFF*2, start at edge E -> busy high for 32 cycles, hi=1, lo=0xFFFFFFFE, done=1 after E+32. A second start at E+5 has no effect.
- DIVU 100/7 -> lo=14, hi=2 after 32 cycles. DIVU 9/0 -> lo=0xFFFFFFFF, hi=9, done after 1 cycle.
- rst at cycle 10 of MULTU -> busy=0, hi=lo=0, no done pulse. A new start is accepted on the following cycle.
- ALU_MD_SIGNED_EN defined: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Undefined: op 11 with start -> busy stays 0.
